// File: rtl/seg_craps_monitor.sv
// Receive-side craps scoreboard for a two-die multiplexed 7-seg bus.
// Decodes each digit, waits for stable throws and applies craps rules.
module seg_craps_monitor #(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic       mHz,
  input  logic       reset,
  input  logic       sel,
  input  logic [6:0] seg,
  input  logic       roll,
  input  logic       new_game,
  output logic [2:0] dice1,
  output logic [2:0] dice2,
  output logic [3:0] sum,
  output logic [3:0] point,
  output logic       result_valid,
  output logic       win,
  output logic       lose,
  output logic       seg_err,
  output logic       timeout,
  output logic       busy
);

  localparam logic [2:0] S_COME  = 3'd0;
  localparam logic [2:0] S_POINT = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WON   = 3'd3;
  localparam logic [2:0] S_LOST  = 3'd4;

  localparam logic [3:0] STB = 4'(STABLE_CNT);
  localparam logic [9:0] TMO = 10'(TIMEOUT);

  function automatic logic [2:0] decode(input logic [6:0] p);
    logic [2:0] v;
    case (p)
      7'b0110000: v = 3'd1;
      7'b1101101: v = 3'd2;
      7'b1111001: v = 3'd3;
      7'b0110011: v = 3'd4;
      7'b1011011: v = 3'd5;
      7'b1011111: v = 3'd6;
      default:    v = 3'd0;
    endcase
    return v;
  endfunction

  logic [2:0] state_q, state_d;
  logic       from_pt_q, from_pt_d;
  logic [2:0] cand1_q, cand1_d;
  logic [2:0] cand2_q, cand2_d;
  logic [3:0] cnt1_q, cnt1_d;
  logic [3:0] cnt2_q, cnt2_d;
  logic [9:0] tmo_q, tmo_d;
  logic [2:0] dice1_q, dice1_d;
  logic [2:0] dice2_q, dice2_d;
  logic [3:0] sum_q, sum_d;
  logic [3:0] point_q, point_d;
  logic       rv_q, rv_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;
  logic       err_q, err_d;
  logic       to_q, to_d;
  logic [2:0] code;
  logic [3:0] tot;

  // Next-state: digit stability tracking, throw acceptance and craps rules
  always_comb begin
    state_d   = state_q;
    from_pt_d = from_pt_q;
    cand1_d   = cand1_q;
    cand2_d   = cand2_q;
    cnt1_d    = cnt1_q;
    cnt2_d    = cnt2_q;
    tmo_d     = tmo_q;
    dice1_d   = dice1_q;
    dice2_d   = dice2_q;
    sum_d     = sum_q;
    point_d   = point_q;
    win_d     = win_q;
    lose_d    = lose_q;
    rv_d      = 1'b0;
    err_d     = 1'b0;
    to_d      = 1'b0;
    code      = decode(seg);
    tot       = 4'd0;
    if (new_game) begin
      state_d = S_COME;
      point_d = 4'd0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
      cnt1_d  = 4'd0;
      cnt2_d  = 4'd0;
      tmo_d   = 10'd0;
    end else begin
      case (state_q)
        S_COME, S_POINT: begin
          if (roll) begin
            state_d   = S_WAIT;
            from_pt_d = (state_q == S_POINT);
            cnt1_d    = 4'd0;
            cnt2_d    = 4'd0;
            tmo_d     = 10'd0;
          end
        end
        S_WAIT: begin
          tmo_d = tmo_q + 10'd1;
          if (code == 3'd0) begin
            err_d = 1'b1;
            if (sel) cnt2_d = 4'd0;
            else     cnt1_d = 4'd0;
          end else if (sel) begin
            if (code == cand2_q) begin
              if (cnt2_q < STB) cnt2_d = cnt2_q + 4'd1;
            end else begin
              cand2_d = code;
              cnt2_d  = 4'd1;
            end
          end else begin
            if (code == cand1_q) begin
              if (cnt1_q < STB) cnt1_d = cnt1_q + 4'd1;
            end else begin
              cand1_d = code;
              cnt1_d  = 4'd1;
            end
          end
          if (cnt1_d == STB && cnt2_d == STB) begin
            tot     = {1'b0, cand1_d} + {1'b0, cand2_d};
            dice1_d = cand1_d;
            dice2_d = cand2_d;
            sum_d   = tot;
            rv_d    = 1'b1;
            if (!from_pt_q) begin
              if (tot == 4'd7 || tot == 4'd11) begin
                win_d   = 1'b1;
                state_d = S_WON;
              end else if (tot == 4'd2 || tot == 4'd3 || tot == 4'd12) begin
                lose_d  = 1'b1;
                state_d = S_LOST;
              end else begin
                point_d = tot;
                state_d = S_POINT;
              end
            end else if (tot == point_q) begin
              win_d   = 1'b1;
              state_d = S_WON;
            end else if (tot == 4'd7) begin
              lose_d  = 1'b1;
              state_d = S_LOST;
            end else begin
              state_d = S_POINT;
            end
          end else if (tmo_d == TMO) begin
            to_d    = 1'b1;
            state_d = from_pt_q ? S_POINT : S_COME;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge mHz) begin
    if (reset) begin
      state_q   <= S_COME;
      from_pt_q <= 1'b0;
      cand1_q   <= 3'd0;
      cand2_q   <= 3'd0;
      cnt1_q    <= 4'd0;
      cnt2_q    <= 4'd0;
      tmo_q     <= 10'd0;
      dice1_q   <= 3'd0;
      dice2_q   <= 3'd0;
      sum_q     <= 4'd0;
      point_q   <= 4'd0;
      rv_q      <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      from_pt_q <= from_pt_d;
      cand1_q   <= cand1_d;
      cand2_q   <= cand2_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      tmo_q     <= tmo_d;
      dice1_q   <= dice1_d;
      dice2_q   <= dice2_d;
      sum_q     <= sum_d;
      point_q   <= point_d;
      rv_q      <= rv_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
      err_q     <= err_d;
      to_q      <= to_d;
    end
  end

  assign dice1        = dice1_q;
  assign dice2        = dice2_q;
  assign sum          = sum_q;
  assign point        = point_q;
  assign result_valid = rv_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign seg_err      = err_q;
  assign timeout      = to_q;
  assign busy         = (state_q == S_WAIT);

endmodule

// File: tb/tb_seg_craps_monitor.sv
// Bench for seg_craps_monitor: directed craps scenarios plus random
// traffic, all checked against a history-based reference model.
module tb_seg_craps_monitor;

  localparam int N   = 4;
  localparam int TMO = 20;

  localparam int M_COME  = 0;
  localparam int M_POINT = 1;
  localparam int M_WAIT  = 2;
  localparam int M_WON   = 3;
  localparam int M_LOST  = 4;

  logic       mHz;
  logic       reset;
  logic       sel;
  logic [6:0] seg;
  logic       roll;
  logic       new_game;
  logic [2:0] dice1;
  logic [2:0] dice2;
  logic [3:0] sum;
  logic [3:0] point;
  logic       result_valid;
  logic       win;
  logic       lose;
  logic       seg_err;
  logic       timeout;
  logic       busy;

  seg_craps_monitor #(
    .STABLE_CNT(N),
    .TIMEOUT(TMO)
  ) dut (
    .mHz(mHz),
    .reset(reset),
    .sel(sel),
    .seg(seg),
    .roll(roll),
    .new_game(new_game),
    .dice1(dice1),
    .dice2(dice2),
    .sum(sum),
    .point(point),
    .result_valid(result_valid),
    .win(win),
    .lose(lose),
    .seg_err(seg_err),
    .timeout(timeout),
    .busy(busy)
  );

  initial mHz = 1'b0;
  always #5 mHz = ~mHz;

  int total = 0;
  int bad   = 0;

  int mode = M_COME;
  bit from_pt = 0;
  int hist1[$];
  int hist2[$];
  int waited = 0;
  int m_d1 = 0, m_d2 = 0, m_sum = 0, m_point = 0;
  int m_rv = 0, m_win = 0, m_lose = 0, m_err = 0, m_to = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat(input int v);
    case (v)
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int dec(input logic [6:0] p);
    for (int v = 1; v <= 6; v++)
      if (pat(v) == p) return v;
    return 0;
  endfunction

  function automatic bit stable(input int q[$]);
    int n;
    n = q.size();
    if (n < N) return 0;
    for (int i = n - N; i < n; i++)
      if (q[i] == 0 || q[i] != q[n-1]) return 0;
    return 1;
  endfunction

  task automatic model(input bit r, input bit ng, input bit rs,
                       input bit s, input logic [6:0] sg);
    int c, t;
    m_rv = 0; m_err = 0; m_to = 0;
    if (rs) begin
      mode = M_COME; from_pt = 0; waited = 0;
      hist1.delete(); hist2.delete();
      m_d1 = 0; m_d2 = 0; m_sum = 0; m_point = 0;
      m_win = 0; m_lose = 0;
    end else if (ng) begin
      mode = M_COME; m_point = 0; m_win = 0; m_lose = 0;
      hist1.delete(); hist2.delete();
    end else if ((mode == M_COME || mode == M_POINT) && r) begin
      from_pt = (mode == M_POINT);
      mode = M_WAIT; waited = 0;
      hist1.delete(); hist2.delete();
    end else if (mode == M_WAIT) begin
      c = dec(sg);
      if (s) hist2.push_back(c);
      else   hist1.push_back(c);
      if (c == 0) m_err = 1;
      waited++;
      if (stable(hist1) && stable(hist2)) begin
        m_d1 = hist1[hist1.size()-1];
        m_d2 = hist2[hist2.size()-1];
        t = m_d1 + m_d2;
        m_sum = t; m_rv = 1;
        if (!from_pt) begin
          if (t == 7 || t == 11) begin m_win = 1; mode = M_WON; end
          else if (t == 2 || t == 3 || t == 12) begin m_lose = 1; mode = M_LOST; end
          else begin m_point = t; mode = M_POINT; end
        end else begin
          if (t == m_point) begin m_win = 1; mode = M_WON; end
          else if (t == 7) begin m_lose = 1; mode = M_LOST; end
          else mode = M_POINT;
        end
      end else if (waited == TMO) begin
        m_to = 1;
        mode = from_pt ? M_POINT : M_COME;
      end
    end
  endtask

  task automatic compare();
    chk("dice1", dice1, m_d1);
    chk("dice2", dice2, m_d2);
    chk("sum", sum, m_sum);
    chk("point", point, m_point);
    chk("result_valid", result_valid, m_rv);
    chk("win", win, m_win);
    chk("lose", lose, m_lose);
    chk("seg_err", seg_err, m_err);
    chk("timeout", timeout, m_to);
    chk("busy", busy, (mode == M_WAIT) ? 1 : 0);
    chk("win_and_lose", win & lose, 0);
  endtask

  task automatic tick(input bit r, input bit ng, input bit rs,
                      input bit s, input logic [6:0] sg);
    roll = r; new_game = ng; reset = rs; sel = s; seg = sg;
    model(r, ng, rs, s, sg);
    @(negedge mHz);
    compare();
  endtask

  task automatic throw(input int a, input int b, input int alt1,
                       input int nalt, input bit bad2,
                       output int lat, output bit got_rv,
                       output bit got_to, output int errs);
    bit s;
    int k1;
    logic [6:0] p;
    tick(1, 0, 0, 1, pat(b));
    lat = 1; errs = 0; got_rv = 0; got_to = 0; s = 0; k1 = 0;
    while (!got_rv && !got_to && lat < 60) begin
      if (!s) begin
        p = (k1 < nalt) ? pat(alt1) : pat(a);
        k1++;
      end else begin
        p = bad2 ? 7'b0000000 : pat(b);
      end
      tick(0, 0, 0, s, p);
      lat++;
      s = ~s;
      if (result_valid) got_rv = 1;
      if (timeout) got_to = 1;
      if (seg_err) errs++;
    end
    chk("throw_end", (got_rv || got_to) ? 1 : 0, 1);
  endtask

  int lat, errs;
  bit grv, gto;
  int ra, rb;
  bit rs_r, ng_r, r_r, s_r;
  logic [6:0] p_r;

  initial begin
    roll = 0; new_game = 0; reset = 1; sel = 0; seg = 7'd0;
    @(negedge mHz);
    tick(0, 0, 1, 0, 7'd0);
    chk("rst_busy", busy, 0);
    chk("rst_win", win, 0);
    tick(0, 0, 0, 0, 7'd0);

    tick(0, 1, 0, 0, 7'd0);
    throw(3, 4, 0, 0, 0, lat, grv, gto, errs);
    chk("t1_lat", lat, 9);
    chk("t1_sum", sum, 7);
    chk("t1_win", win, 1);
    chk("t1_point", point, 0);

    tick(0, 1, 0, 0, 7'd0);
    throw(2, 3, 0, 0, 0, lat, grv, gto, errs);
    chk("t2_point", point, 5);
    chk("t2_nowin", win, 0);
    throw(1, 4, 0, 0, 0, lat, grv, gto, errs);
    chk("t2_sum", sum, 5);
    chk("t2_win", win, 1);
    tick(1, 0, 0, 0, pat(2));
    chk("t2_ignored", busy, 0);
    tick(0, 0, 0, 1, pat(2));

    tick(0, 1, 0, 0, 7'd0);
    throw(3, 3, 0, 0, 0, lat, grv, gto, errs);
    chk("t3_point", point, 6);
    throw(4, 3, 0, 0, 0, lat, grv, gto, errs);
    chk("t3_lose", lose, 1);
    chk("t3_point_kept", point, 6);
    tick(1, 0, 0, 0, pat(1));
    chk("t3_lost_idle", busy, 0);

    tick(0, 1, 0, 0, 7'd0);
    throw(6, 4, 5, 3, 0, lat, grv, gto, errs);
    chk("t4_lat", lat, 14);
    chk("t4_dice1", dice1, 6);
    chk("t4_dice2", dice2, 4);

    tick(0, 1, 0, 0, 7'd0);
    throw(2, 0, 0, 0, 1, lat, grv, gto, errs);
    chk("t5_to", gto, 1);
    chk("t5_rv", grv, 0);
    chk("t5_lat", lat, 21);
    chk("t5_errs", errs, 10);
    throw(1, 1, 0, 0, 0, lat, grv, gto, errs);
    chk("t5_next_rv", grv, 1);
    chk("t5_next_lose", lose, 1);

    tick(0, 1, 0, 0, 7'd0);
    tick(1, 0, 0, 1, pat(2));
    tick(0, 0, 0, 0, pat(2));
    tick(0, 0, 0, 1, pat(2));
    tick(0, 0, 1, 0, pat(2));
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_sum", sum, 0);
    tick(1, 0, 0, 1, pat(3));
    tick(0, 0, 0, 0, pat(3));
    tick(1, 1, 0, 1, pat(3));
    chk("t6_ng_busy", busy, 0);
    chk("t6_ng_rv", result_valid, 0);
    chk("t6_ng_flags", {win, lose, timeout}, 0);
    throw(5, 6, 0, 0, 0, lat, grv, gto, errs);
    chk("t6_comeout_win", win, 1);

    ra = 1; rb = 1; s_r = 0;
    for (int i = 0; i < 4000; i++) begin
      rs_r = ($urandom_range(0, 299) == 0);
      ng_r = ($urandom_range(0, 79) == 0);
      r_r  = ($urandom_range(0, 11) == 0);
      if (r_r) begin
        ra = $urandom_range(1, 6);
        rb = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 7) != 0) s_r = ~s_r;
      if ($urandom_range(0, 11) == 0) p_r = 7'($urandom);
      else p_r = pat(s_r ? rb : ra);
      tick(r_r, ng_r, rs_r, s_r, p_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_craps_monitor.md
Name: seg_craps_monitor

Overview:
- Receive-side checker for the two-die multiplexed 7-segment display bus (sel, seg) driven by the dice-game block.
- Samples seg on each sel phase and decodes the pattern back to a die value (1..6).
- Accepts a throw only after both digits are stable, then applies craps rules (come-out, point) independently of the game block.
- Used on the bench and in-system as a scoreboard that cross-checks the game's win/lose lamps.

Parameters:
- STABLE_CNT, 4: consecutive identical valid samples required per digit phase before that digit is accepted (1..15).
- TIMEOUT, 1023: max cycles in WAIT after a roll before abort (10-bit counter).

Ports:
- mHz  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sel  input  1  display phase; 0 = seg carries die 1, 1 = seg carries die 2
- seg  input  7  segment pattern {a,b,c,d,e,f,g}, active-high
- roll  input  1  single-cycle pulse: a throw has started, wait for new stable digits
- new_game  input  1  single-cycle pulse: clear game state back to come-out
- dice1  output  3  last accepted die 1 value
- dice2  output  3  last accepted die 2 value
- sum  output  4  dice1+dice2 of last accepted throw (2..12)
- point  output  4  current point; 0 when no point is set
- result_valid  output  1  one-cycle pulse when a throw is accepted and evaluated
- win  output  1  sticky win flag
- lose  output  1  sticky lose flag
- seg_err  output  1  one-cycle pulse per invalid pattern sampled while in WAIT
- timeout  output  1  one-cycle pulse when WAIT aborts
- busy  output  1  high in WAIT

Behaviour:
- Reset (synchronous, highest priority): all outputs 0, both stability counters 0, FSM in COMEOUT_IDLE.
- Decode table:
  - 0110000 = 1
  - 1101101 = 2
  - 1111001 = 3
  - 0110011 = 4
  - 1011011 = 5
  - 1011111 = 6
  - Any other pattern is invalid.
- States: COMEOUT_IDLE, POINT_IDLE, WAIT, WON, LOST. A 1-bit flag records which idle state to return to.
- Roll acceptance:
  - roll in COMEOUT_IDLE or POINT_IDLE enters WAIT, clears both counters and the timeout counter, and sets busy=1 next cycle.
  - roll in WAIT, WON or LOST is ignored.
- Sampling in WAIT, each cycle, for the phase given by sel:
  - Valid code equal to that phase's held candidate: increment the counter, saturating at STABLE_CNT.
  - Valid code that differs from the candidate: load the new candidate and set the counter to 1.
  - Invalid code: counter = 0 and seg_err pulses in the following cycle.
- Acceptance: on the edge after both counters read STABLE_CNT, leave WAIT and, on that same edge:
  - latch dice1 and dice2;
  - set sum = dice1 + dice2 (4-bit, no overflow possible);
  - pulse result_valid for 1 cycle and drop busy.
- Minimum latency from roll is 2*STABLE_CNT+1 cycles with sel toggling every cycle.
- Evaluation from come-out:
  - sum 7 or 11: win=1, go WON.
  - sum 2, 3 or 12: lose=1, go LOST.
  - Otherwise: point=sum, go POINT_IDLE.
- Evaluation from point:
  - sum==point: win=1, go WON.
  - sum==7: lose=1, go LOST.
  - Otherwise stay in POINT_IDLE with point unchanged.
- Timeout:
  - The counter increments every cycle in WAIT.
  - When it reaches TIMEOUT without acceptance: pulse timeout, return to the idle state WAIT was entered from.
  - dice, sum, point and win/lose stay unchanged.
- new_game, in any state:
  - next cycle: COMEOUT_IDLE, point=0, win=0, lose=0, busy=0, counters cleared;
  - dice1, dice2 and sum are held.
  - new_game beats roll when both are asserted in the same cycle.
  - new_game during WAIT aborts the throw without result_valid or timeout.
- Mid-throw reset behaves exactly like power-on reset.
- win and lose are never both 1.

Test Plan:
- Reset, new_game, roll; drive die1=3 (1111001) and die2=4 (0110011) alternating with sel toggling. Required: result_valid exactly 9 cycles after roll (STABLE_CNT=4), sum=7, win=1, point=0.
- Come-out 2+3 gives point=5, no win. Second roll 1+4 gives sum=5 and win=1. A third roll is then ignored: busy stays 0.
- Point 6 (3+3), then roll 4+3. Required: lose=1, point still 6, state LOST.
- Die 1 shows 5 for 3 samples, then switches to 6. Required: the counter restarts, acceptance is delayed by 3 die-1 samples, and dice1=6 is latched.
- Die 2 held at 0000000 after roll with TIMEOUT=20. Required:
  - seg_err pulses on each die-2 sample;
  - timeout pulses 20 cycles after WAIT entry, with no result_valid;
  - the next roll is accepted.
- Assert reset and separately new_game mid-WAIT (with roll in the same cycle as new_game). Required: all flags 0, busy=0, no result_valid, and the state is COMEOUT_IDLE.
